frame_diff_tracker: RTL and testbench

//  Parametrised successor of the tile frame tracker. Keeps a shadow copy of the

---
 rtl/frame_diff_tracker_pkg.sv | 19 +
 rtl/frame_diff_tracker_tile_store.sv | 33 +++
 rtl/frame_diff_tracker.sv | 176 +++++++++++++++++
 tb/tb_frame_diff_tracker.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_diff_tracker_pkg.sv
// Shared types for the frame diff tracker: tile object codes and FSM states.
package frame_diff_tracker_pkg;

  // Object codes as produced by the game-logic cell encoder.
  typedef enum logic [2:0] {
    BLANK      = 3'd0,
    SNAKE_HEAD = 3'd1,
    SNAKE_BODY = 3'd2,
    APPLE      = 3'd3,
    BORDER     = 3'd4
  } obj_code_t;

  // SCAN: accepting cells freely. WAIT: a diff is held for the drawer.
  typedef enum logic [0:0] {
    StScan = 1'b0,
    StWait = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/frame_diff_tracker_tile_store.sv
// Shadow tile map: register array with one async read port and one sync write port.
module frame_diff_tracker_tile_store
  import frame_diff_tracker_pkg::*;
#(
  parameter int unsigned Depth = 192,
  parameter int unsigned CodeW = 3,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [CodeW-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [CodeW-1:0] rdata
);

  logic [CodeW-1:0] mem_q [Depth];

  // Clear every tile to BLANK on reset, otherwise write the addressed tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= CodeW'(BLANK);
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/frame_diff_tracker.sv
// Scans per-cell object codes in raster order and forwards only changed tiles
// to the drawer over valid/ready, with forced redraw and per-frame diff count.
module frame_diff_tracker
  import frame_diff_tracker_pkg::*;
#(
  parameter int unsigned GRID_W    = 16,
  parameter int unsigned GRID_H    = 12,
  parameter int unsigned CODE_W    = 3,
  parameter bit          BORDER_EN = 1'b1,
  parameter int unsigned CNT_W     = $clog2(GRID_W * GRID_H + 1),
  parameter int unsigned XW        = $clog2(GRID_W),
  parameter int unsigned YW        = $clog2(GRID_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cell_valid,
  output logic              cell_ready,
  input  logic [CODE_W-1:0] obj_in,
  output logic [XW-1:0]     cell_x,
  output logic [YW-1:0]     cell_y,
  input  logic              force_redraw,
  output logic              diff_valid,
  input  logic              diff_ready,
  output logic [CODE_W-1:0] diff_code,
  output logic [XW-1:0]     diff_x,
  output logic [YW-1:0]     diff_y,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_diffs
);

  localparam int unsigned NumCells = GRID_W * GRID_H;
  localparam int unsigned AddrW    = $clog2(NumCells);

  fsm_state_t        state_q, state_d;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [CODE_W-1:0] diff_code_q;
  logic [XW-1:0]     diff_x_q;
  logic [YW-1:0]     diff_y_q;
  logic              frame_done_q;
  logic [CNT_W-1:0]  frame_diffs_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              force_pend_q;
  logic              force_active_q;

  logic              x_last, y_last, at_origin, at_last, on_edge;
  logic [CODE_W-1:0] eff_code;
  logic [CODE_W-1:0] shadow_code;
  logic [AddrW-1:0]  addr;
  logic              accept;
  logic              force_now;
  logic              is_diff;

  assign x_last    = (x_q == XW'(GRID_W - 1));
  assign y_last    = (y_q == YW'(GRID_H - 1));
  assign at_origin = (x_q == '0) && (y_q == '0);
  assign at_last   = x_last && y_last;
  assign on_edge   = (x_q == '0) || (y_q == '0) || x_last || y_last;
  assign eff_code  = (BORDER_EN && on_edge) ? CODE_W'(BORDER) : obj_in;
  assign addr      = AddrW'(32'(y_q) * GRID_W + 32'(x_q));

  frame_diff_tracker_tile_store #(
    .Depth (NumCells),
    .CodeW (CODE_W),
    .AddrW (AddrW)
  ) u_tile_store (
    .clk   (clk),
    .rst   (rst),
    .we    (accept),
    .waddr (addr),
    .wdata (eff_code),
    .raddr (addr),
    .rdata (shadow_code)
  );

  // Handshake, diff detection and next-state decode.
  always_comb begin
    cell_ready = 1'b0;
    accept     = 1'b0;
    force_now  = 1'b0;
    is_diff    = 1'b0;
    state_d    = state_q;
    // Nothing is accepted while reset is held.
    cell_ready = !rst && ((state_q == StScan) || diff_ready);
    accept     = cell_valid && cell_ready;
    // Tile (0,0) already belongs to the frame a pending force applies to.
    force_now  = at_origin ? force_pend_q : force_active_q;
    is_diff    = accept && ((eff_code != shadow_code) || force_now);
    unique case (state_q)
      StScan: if (is_diff) state_d = StWait;
      StWait: if (diff_ready && !is_diff) state_d = StScan;
      default: state_d = StScan;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StScan;
    end else begin
      state_q <= state_d;
    end
  end

  // Raster pointer, advanced on every accepted cell.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (accept) begin
      if (x_last) begin
        x_q <= '0;
        y_q <= y_last ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  // Diff output registers, loaded whenever an accepted cell is a diff.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_code_q <= '0;
      diff_x_q    <= '0;
      diff_y_q    <= '0;
    end else if (is_diff) begin
      diff_code_q <= eff_code;
      diff_x_q    <= x_q;
      diff_y_q    <= y_q;
    end
  end

  // Per-frame diff counter; result published with frame_done after the last tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      frame_diffs_q <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_done_q <= accept && at_last;
      if (accept) begin
        if (at_last) begin
          frame_diffs_q <= cnt_q + CNT_W'(is_diff);
          cnt_q         <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(is_diff);
        end
      end
    end
  end

  // Force flags: a request is latched and only takes effect from tile (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      force_pend_q   <= 1'b0;
      force_active_q <= 1'b0;
    end else begin
      if (force_redraw) force_pend_q <= 1'b1;
      if (accept && at_origin) begin
        force_active_q <= force_pend_q;
        force_pend_q   <= force_redraw;
      end
      if (accept && at_last) force_active_q <= 1'b0;
    end
  end

  assign cell_x      = x_q;
  assign cell_y      = y_q;
  assign diff_valid  = (state_q == StWait);
  assign diff_code   = diff_code_q;
  assign diff_x      = diff_x_q;
  assign diff_y      = diff_y_q;
  assign frame_done  = frame_done_q;
  assign frame_diffs = frame_diffs_q;

endmodule

// File: tb/tb_frame_diff_tracker.sv
// Directed bench for frame_diff_tracker with a reference tile map and diff queue.
module tb_frame_diff_tracker;
  import frame_diff_tracker_pkg::*;

  localparam int GW   = 16;
  localparam int GH   = 12;
  localparam int N    = GW * GH;
  localparam int CW   = 3;
  localparam int XW   = 4;
  localparam int YW   = 4;
  localparam int CNTW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            cell_valid;
  logic            cell_ready;
  logic [CW-1:0]   obj_in;
  logic [XW-1:0]   cell_x;
  logic [YW-1:0]   cell_y;
  logic            force_redraw;
  logic            diff_valid;
  logic            diff_ready;
  logic [CW-1:0]   diff_code;
  logic [XW-1:0]   diff_x;
  logic [YW-1:0]   diff_y;
  logic            frame_done;
  logic [CNTW-1:0] frame_diffs;

  frame_diff_tracker #(
    .GRID_W    (GW),
    .GRID_H    (GH),
    .CODE_W    (CW),
    .BORDER_EN (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cell_valid   (cell_valid),
    .cell_ready   (cell_ready),
    .obj_in       (obj_in),
    .cell_x       (cell_x),
    .cell_y       (cell_y),
    .force_redraw (force_redraw),
    .diff_valid   (diff_valid),
    .diff_ready   (diff_ready),
    .diff_code    (diff_code),
    .diff_x       (diff_x),
    .diff_y       (diff_y),
    .frame_done   (frame_done),
    .frame_diffs  (frame_diffs)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] code;
  } diff_t;

  int vectors = 0;
  int miscompares = 0;

  logic [CW-1:0] req [N];
  logic [CW-1:0] mdl [N];
  diff_t         q [$];
  int  px = 0, py = 0, fcount = 0, exp_fd = 0;
  int  border_cnt = 0, run_len = 0, max_run = 0, last_fd = -1, done_cnt = 0;
  int  held = 0, stall_x = -1, stall_y = -1;
  bit  frame_forced = 1'b0, exp_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [CW-1:0] eff_of(input int x, input int y, input logic [CW-1:0] o);
    if (x == 0 || y == 0 || x == GW - 1 || y == GH - 1) return CW'(BORDER);
    return o;
  endfunction

  // One clock: check outputs against the reference, update it, then check frame_done.
  task automatic tick(output bit acc);
    int            idx;
    logic [CW-1:0] e;
    bit            rdy;
    diff_t         d;
    acc = 1'b0;
    @(negedge clk);
    rdy = (q.size() == 0) || diff_ready;
    if (q.size() != 0) begin
      chk("diff_valid_hi", diff_valid, 1);
      chk("diff_x", diff_x, q[0].x);
      chk("diff_y", diff_y, q[0].y);
      chk("diff_code", diff_code, q[0].code);
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (diff_ready) begin
        if (q[0].code == CW'(BORDER)) border_cnt++;
        void'(q.pop_front());
      end
    end else begin
      chk("diff_valid_lo", diff_valid, 0);
      run_len = 0;
    end
    chk("cell_x", cell_x, px);
    chk("cell_y", cell_y, py);
    chk("cell_ready", cell_ready, rdy);
    if (cell_valid && rdy) begin
      acc = 1'b1;
      idx = py * GW + px;
      e = eff_of(px, py, obj_in);
      if (e !== mdl[idx] || frame_forced) begin
        d.x = XW'(px);
        d.y = YW'(py);
        d.code = e;
        q.push_back(d);
        fcount++;
      end
      mdl[idx] = e;
      if (px == GW - 1 && py == GH - 1) begin
        exp_done = 1'b1;
        exp_fd = fcount;
        fcount = 0;
      end
      if (px == GW - 1) begin
        px = 0;
        py = (py == GH - 1) ? 0 : py + 1;
      end else begin
        px++;
      end
    end
    @(posedge clk);
    #1;
    chk("frame_done", frame_done, exp_done);
    if (exp_done) begin
      chk("frame_diffs", frame_diffs, exp_fd);
      last_fd = int'(frame_diffs);
      done_cnt++;
    end
    exp_done = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    cell_valid = 1'b0;
    diff_ready = 1'b1;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  // Feeds one frame from req[]; optional force pulse, drawer stall and early stop.
  task automatic run_frame(input bit forced, input int pulse_idx, input int stall_idx,
                           input int stall_len, input int stop_idx);
    int accepted = 0;
    int budget = 0;
    int stall = 0;
    int idx;
    bit acc;
    frame_forced = forced;
    max_run = 0;
    run_len = 0;
    border_cnt = 0;
    while (accepted < N) begin
      idx = py * GW + px;
      cell_valid = 1'b1;
      diff_ready = (stall == 0);
      // While stalled the offered code is junk; it must be ignored.
      obj_in = (stall != 0) ? CW'(SNAKE_BODY) : req[idx];
      force_redraw = (idx == pulse_idx);
      if (stall != 0) begin
        held += int'(diff_valid);
        stall_x = int'(cell_x);
        stall_y = int'(cell_y);
        stall--;
      end
      tick(acc);
      force_redraw = 1'b0;
      if (acc) begin
        accepted++;
        if (idx == stall_idx) stall = stall_len;
        if (idx == stop_idx) break;
      end
      budget++;
      if (budget > 4 * N) begin
        chk("frame_budget", accepted, N);
        break;
      end
    end
    cell_valid = 1'b0;
    diff_ready = 1'b1;
    frame_forced = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      req[i] = CW'(BLANK);
      mdl[i] = CW'(BLANK);
    end
    rst = 1'b1;
    cell_valid = 1'b0;
    obj_in = '0;
    force_redraw = 1'b0;
    diff_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_diff_valid", diff_valid, 0);
    chk("rst_cell_x", cell_x, 0);
    chk("rst_cell_y", cell_y, 0);
    chk("rst_diff_code", diff_code, 0);
    chk("rst_diff_x", diff_x, 0);
    chk("rst_diff_y", diff_y, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_diffs", frame_diffs, 0);
    chk("rst_cell_ready", cell_ready, 0);
    rst = 1'b0;

    // Frame 1: blank map, every edge tile becomes BORDER: 16*12 - 14*10 = 52.
    run_frame(1'b0, -1, -1, 0, -1);
    idle(2);
    chk("f1_frame_diffs", last_fd, 52);
    chk("f1_border_diffs", border_cnt, 52);
    chk("f1_done_count", done_cnt, 1);

    // Frame 2: identical input, nothing changes.
    run_frame(1'b0, -1, -1, 0, -1);
    chk("f2_frame_diffs", last_fd, 0);
    chk("f2_done_count", done_cnt, 2);

    // Frame 3: APPLE at (5,4), drawer stalled for 10 cycles after it.
    req[4 * GW + 5] = CW'(APPLE);
    run_frame(1'b0, -1, 4 * GW + 5, 10, -1);
    chk("f3_frame_diffs", last_fd, 1);
    chk("f3_held_cycles", held, 10);
    chk("f3_stall_x", stall_x, 6);
    chk("f3_stall_y", stall_y, 4);

    // Frame 4: force pulsed mid-frame does not affect this frame.
    run_frame(1'b0, 100, -1, 0, -1);
    chk("f4_frame_diffs", last_fd, 0);

    // Frame 5: forced redraw reports every tile.
    run_frame(1'b1, -1, -1, 0, -1);
    chk("f5_frame_diffs", last_fd, 192);

    // Frame 6: force does not persist.
    run_frame(1'b0, -1, -1, 0, -1);
    chk("f6_frame_diffs", last_fd, 0);

    // Frame 7: adjacent changes stream back-to-back without a bubble.
    req[3 * GW + 3] = CW'(SNAKE_HEAD);
    req[3 * GW + 4] = CW'(SNAKE_BODY);
    run_frame(1'b0, -1, -1, 0, -1);
    chk("f7_frame_diffs", last_fd, 2);
    chk("f7_back_to_back", max_run, 2);

    // Frame 8: reset while the (7,2) diff is being offered.
    req[2 * GW + 7] = CW'(APPLE);
    run_frame(1'b0, -1, -1, 0, 2 * GW + 7);
    chk("f8_pre_valid", diff_valid, 1);
    chk("f8_pre_x", diff_x, 7);
    chk("f8_pre_y", diff_y, 2);
    chk("f8_pre_code", diff_code, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("f8_rst_valid", diff_valid, 0);
    chk("f8_rst_cell_x", cell_x, 0);
    chk("f8_rst_cell_y", cell_y, 0);
    chk("f8_rst_frame_diffs", frame_diffs, 0);
    rst = 1'b0;
    q.delete();
    px = 0;
    py = 0;
    fcount = 0;
    for (int i = 0; i < N; i++) begin
      req[i] = CW'(BLANK);
      mdl[i] = CW'(BLANK);
    end

    // Frame 9: cleared shadow re-reports all border tiles.
    run_frame(1'b0, -1, -1, 0, -1);
    idle(2);
    chk("f9_frame_diffs", last_fd, 52);
    chk("f9_border_diffs", border_cnt, 52);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
